// File: rtl/maxpool_22_p_pkg.sv
// Shared definitions for the FP32 pooling/activation stages.
// Holds the binary32 width, the sign-bit index and the total-order key
// used to compare binary32 values with a plain unsigned compare.
package maxpool_22_p_pkg;

  localparam int FP32_W   = 32;
  localparam int SIGN_BIT = 31;

  // Maps binary32 onto an unsigned key whose order matches numeric order.
  // Negative values are bit-inverted, so more negative values get smaller keys.
  // Positive values get the sign bit set, so they sit above every negative value.
  // The result is -0 (key 0x7FFFFFFF) < +0 (key 0x80000000).
  function automatic logic [FP32_W-1:0] fp_key(input logic [FP32_W-1:0] x);
    logic [FP32_W-1:0] k;
    if (x[SIGN_BIT]) begin
      k = ~x;
    end else begin
      k = x ^ 32'h8000_0000;
    end
    return k;
  endfunction

endpackage

// File: rtl/maxpool_22_p_fp_max.sv
// Combinational binary32 maximum.
// Ports: a, b - operands; max - the operand with the larger key.
// When the keys are equal the result is a.
module maxpool_22_p_fp_max
  import maxpool_22_p_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] max
);

  // Select b only when it is strictly larger, so ties fall back to a.
  always_comb begin
    max = a;
    if (fp_key(b) > fp_key(a)) begin
      max = b;
    end else begin
      max = a;
    end
  end

endmodule

// File: rtl/maxpool_22_p.sv
// Streaming 2x2, stride-2 max-pool over a D x D row-major binary32 raster.
// Emits a P x P raster, where P = D/2. For odd D the last row and column are dropped.
// Ports: clk, reset (synchronous, active-high), valid_in/pxl_in (input stream),
//        pxl_out/valid_out (pooled stream; valid_out is a one-cycle pulse).
module maxpool_22_p
  import maxpool_22_p_pkg::*;
#(
  parameter int D          = 299,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int P  = D / 2;
  // The counters are wide enough to also hold the value 2P, which is used as the accept limit.
  localparam int CW = $clog2(D + 1);
  localparam int AW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);
  localparam logic [CW-1:0] LIM  = CW'(2 * P);

  logic [CW-1:0]     col;
  logic [CW-1:0]     row;
  logic [CW-1:0]     col_nxt;
  logic [CW-1:0]     row_nxt;
  logic [FP32_W-1:0] hold;
  logic [FP32_W-1:0] lbuf [P];
  logic [FP32_W-1:0] lbuf_rd;
  logic [FP32_W-1:0] h_max;
  logic [FP32_W-1:0] pooled;
  logic [AW-1:0]     idx;
  logic              accept;
  logic              wr_en;

  assign idx     = AW'(col >> 1);
  assign lbuf_rd = lbuf[idx];

  // Horizontal pair: the held even-column pixel against the current odd-column pixel.
  maxpool_22_p_fp_max u_h_max (
    .a   (hold),
    .b   (pxl_in),
    .max (h_max)
  );

  // Vertical pair: the top-row result from the line buffer against the bottom-row pair.
  maxpool_22_p_fp_max u_v_max (
    .a   (lbuf_rd),
    .b   (h_max),
    .max (pooled)
  );

  // Raster position advance, window accept, and line-buffer write enable.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    accept  = 1'b0;
    wr_en   = 1'b0;
    if (valid_in) begin
      if (col == LAST) begin
        col_nxt = '0;
        if (row == LAST) begin
          row_nxt = '0;
        end else begin
          row_nxt = row + CW'(1);
        end
      end else begin
        col_nxt = col + CW'(1);
      end
      accept = (col < LIM) && (row < LIM);
    end else begin
      accept = 1'b0;
    end
    // A line-buffer write happens on an accepted pixel in an odd column and an even row.
    // Reset blocks the write because a simultaneous reset takes priority over valid_in.
    wr_en = accept && col[0] && !row[0] && !reset;
  end

  // Line buffer that holds the top-row pair maxima, written with a synchronous write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lbuf[idx] <= h_max;
    end
  end

  // Counters, the hold register and the registered pooled output.
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      pxl_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      col       <= col_nxt;
      row       <= row_nxt;
      if (accept) begin
        if (!col[0]) begin
          hold <= pxl_in;
        end else if (row[0]) begin
          pxl_out   <= pooled;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_22_p.sv
// Directed testbench for maxpool_22_p, with instances for D=4 and D=5.
module tb_maxpool_22_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        v4, v5;
  logic [31:0] p4, p5;
  logic [31:0] o4, o5;
  logic        ov4, ov5;
  logic [31:0] last4, last5;
  int          n_asrt = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  maxpool_22_p #(.D(4), .data_width(32)) u4 (
    .clk(clk), .reset(rst), .valid_in(v4), .pxl_in(p4), .pxl_out(o4), .valid_out(ov4)
  );
  maxpool_22_p #(.D(5), .data_width(32)) u5 (
    .clk(clk), .reset(rst), .valid_in(v5), .pxl_in(p5), .pxl_out(o5), .valid_out(ov5)
  );

  // Encodes a small nonzero integer as binary32.
  function automatic logic [31:0] f32(input int n);
    int a;
    int e;
    logic [31:0] m;
    a = (n < 0) ? -n : n;
    e = 0;
    for (int i = 0; i < 31; i++) if ((a >> i) != 0) e = i;
    m = (32'(a) << (23 - e)) & 32'h007F_FFFF;
    return {(n < 0) ? 1'b1 : 1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic hit4(input int k);
    return (k == 6) || (k == 8) || (k == 14) || (k == 16);
  endfunction

  function automatic logic [31:0] asc4(input int k);
    case (k)
      6:  return 32'h40C0_0000;
      8:  return 32'h4100_0000;
      14: return 32'h4160_0000;
      16: return 32'h4180_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] neg4(input int k);
    case (k)
      6:  return 32'hBF80_0000;
      8:  return 32'hC040_0000;
      14: return 32'hC110_0000;
      16: return 32'hC130_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] asc5(input int k);
    case (k)
      7:  return 32'h40E0_0000;
      9:  return 32'h4110_0000;
      17: return 32'h4188_0000;
      19: return 32'h4198_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on instance 4 or 5, then a check of that instance's outputs.
  task automatic cyc(input int which, input logic v, input logic [31:0] p,
                     input logic ev, input logic [31:0] ep, input string tag);
    @(negedge clk);
    if (which == 4) begin
      v4 = v; p4 = p; v5 = 1'b0;
    end else begin
      v5 = v; p5 = p; v4 = 1'b0;
    end
    @(posedge clk);
    #1;
    if (which == 4) begin
      chk({tag, "_valid"}, {31'd0, ov4}, {31'd0, ev});
      if (ev) last4 = ep;
      chk({tag, "_pxl"}, o4, last4);
    end else begin
      chk({tag, "_valid"}, {31'd0, ov5}, {31'd0, ev});
      if (ev) last5 = ep;
      chk({tag, "_pxl"}, o5, last5);
    end
  endtask

  initial begin
    int k;
    logic v;
    logic [31:0] zp [16];
    rst = 1'b1; v4 = 1'b0; v5 = 1'b0; p4 = 32'h0; p5 = 32'h0;
    last4 = 32'h0; last5 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid4", {31'd0, ov4}, 32'd0);
    chk("rst_pxl4", o4, 32'h0);
    chk("rst_valid5", {31'd0, ov5}, 32'd0);
    chk("rst_pxl5", o5, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // D=5, two back-to-back frames: only four windows are produced per frame.
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 25; i++)
        cyc(5, 1'b1, f32(i), (asc5(i) != 32'h0), asc5(i), "d5_asc");

    // D=4 ascending, then descending negatives, then signed-zero windows.
    for (int i = 1; i <= 16; i++) cyc(4, 1'b1, f32(i), hit4(i), asc4(i), "d4_asc");
    for (int i = 1; i <= 16; i++) cyc(4, 1'b1, f32(-i), hit4(i), neg4(i), "d4_neg");
    for (int i = 0; i < 16; i++) zp[i] = 32'h8000_0000;
    zp[1] = 32'h0000_0000;
    zp[2] = 32'h0000_0000;
    for (int i = 1; i <= 16; i++)
      cyc(4, 1'b1, zp[i-1], hit4(i), (i <= 8) ? 32'h0000_0000 : 32'h8000_0000, "d4_zero");

    // Random stalls across two frames.
    for (int f = 0; f < 2; f++) begin
      k = 1;
      for (int c = 0; c < 200 && k <= 16; c++) begin
        v = 1'($urandom_range(0, 1));
        if (v) begin
          cyc(4, 1'b1, f32(k), hit4(k), asc4(k), "d4_stall");
          k++;
        end else begin
          cyc(4, 1'b0, f32(99), 1'b0, 32'h0, "d4_idle");
        end
      end
      chk("stall_done", 32'(k), 32'd17);
    end

    // Mid-frame reset after the seventh pixel; reset overrides a simultaneous valid_in.
    for (int i = 1; i <= 7; i++) cyc(4, 1'b1, f32(i), hit4(i), asc4(i), "d4_part");
    @(negedge clk);
    rst = 1'b1; v4 = 1'b1; p4 = f32(100);
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, ov4}, 32'd0);
    chk("mid_rst_pxl", o4, 32'h0);
    last4 = 32'h0;
    @(negedge clk);
    rst = 1'b0; v4 = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, ov4}, 32'd0);
    for (int i = 1; i <= 16; i++) cyc(4, 1'b1, f32(i), hit4(i), asc4(i), "d4_after_rst");
    cyc(4, 1'b0, 32'h0, 1'b0, 32'h0, "d4_tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_22_p.md
Name: maxpool_22_p

Overview:
- Streaming 2x2 max-pool, stride 2, on IEEE-754 single-precision pixels.
- Sits directly downstream of the 3x1 convolution stage and consumes its pxl_out/valid_out raster stream, D x D per frame, row-major.
- Emits a P x P raster stream, P = floor(D/2), one pixel per window on a valid_out pulse.
- For odd D, the trailing column and row are dropped (no padding).

Parameters:
- D, 299, input frame width and height in pixels.
- data_width, 32, pixel width; the value encoding is fixed to IEEE-754 binary32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  pxl_in carries the next raster pixel this cycle.
- pxl_in  input  data_width  input pixel (binary32).
- pxl_out  output  data_width  pooled pixel (binary32).
- valid_out  output  1  single-cycle pulse; pxl_out holds a new window result.

Behaviour:
- Reset values:
  - valid_out=0, pxl_out=0.
  - col=0, row=0, hold register=0.
  - Line buffer contents are don't-care, because every entry is written before it is read.
- Counters:
  - col runs 0..D-1 and advances only on valid_in.
  - At col=D-1, col wraps to 0 and row increments.
  - At row=D-1 and col=D-1, both wrap to 0 and the next frame starts with no gap.
- valid_in=0: all state holds; valid_out=0 on the next edge; pxl_out keeps its last value.
- Comparison (fp_max):
  - key(x) = x[31] ? ~x : x ^ 32'h80000000; the larger key wins.
  - Equal keys return operand a.
  - +0 beats -0.
  - NaN is not expected; it is ordered by key with no special case.
- Accepted pixels are those with col < 2P and row < 2P; all others are counted and ignored.
- Even col, accepted: hold <= pxl_in.
- Odd col, accepted: m = max(hold, pxl_in).
  - Even row: lbuf[col>>1] <= m.
  - Odd row: pxl_out <= max(lbuf[col>>1], m) and valid_out <= 1.
- Line buffer: P entries x data_width, one write or one read per accepted odd-col pixel. It never needs a simultaneous read and write.
- Latency: valid_out rises exactly 1 cycle after the clock edge that samples the window's bottom-right pixel.
- Throughput:
  - Back-to-back windows produce valid_out on alternate cycles at most.
  - P*P pulses per frame (22201 for D=299).
- Reset mid-frame: counters return to 0 and any partial window is discarded. The first valid_in after reset is pixel (0,0). valid_out is 0 during and on the cycle after reset.
- Reset priority: reset takes precedence over a simultaneous valid_in.

Decomposition:
- Shared package: FP32 width constant, sign-bit index, and the key() ordering function. The same ordering is reused by later pooling/ReLU stages.
- One sub-module, fp_max:
  - Combinational; inputs a, b; output max.
  - Tie and signed-zero rules as above.
  - Instantiated twice: horizontal pair, then vertical.
- Top level holds the counters, the hold register, the line buffer (inferred RAM, synchronous write) and the output register.

Test Plan:
- D=4, continuous valid_in, pixels 1.0..16.0 row-major -> valid_out pulses carry 0x40C00000, 0x41000000, 0x41600000, 0x41800000 (6, 8, 14, 16), each 1 cycle after pixels 6, 8, 14 and 16 are sampled.
- D=4, pixels -1.0..-16.0 -> 0xBF800000, 0xC0400000, 0xC1100000, 0xC1300000 (-1, -3, -9, -11).
- D=5, pixels 1.0..25.0 -> exactly 4 outputs: 7, 9, 17, 19 (0x40E00000, 0x41100000, 0x41880000, 0x41980000). Column 4 and row 4 produce no valid_out.
- D=4 ascending input, valid_in deasserted on random cycles (~50%) -> same 4 values in order; no valid_out while stalled; two consecutive frames give identical results.
- Signed zero: window {0x80000000, 0x00000000, 0x80000000, 0x80000000} -> 0x00000000.
- Reset mid-frame: reset asserted after the 7th pixel of frame 1, then the D=4 ascending frame is re-sent -> no output from the partial frame; the outputs are 6, 8, 14, 16.
